// File: rtl/mystery2_descrambler_if.sv
// Mystery2 descrambler bus: scrambled-word input side and recovered-pair output side.
// The master modport drives the scrambled stream; the slave modport is the descrambler.
interface mystery2_descrambler_if #(
    parameter int unsigned ERRCNT_W = 8
);
    logic                in_valid;
    logic [15:0]         in_word;
    logic                in_sync;
    logic [7:0]          a_out;
    logic [7:0]          b_out;
    logic                out_valid;
    logic                err;
    logic                locked;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output in_valid,
        output in_word,
        output in_sync,
        input  a_out,
        input  b_out,
        input  out_valid,
        input  err,
        input  locked,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  in_sync,
        output a_out,
        output b_out,
        output out_valid,
        output err,
        output locked,
        output err_count
    );
endinterface

// File: rtl/mystery2_descrambler.sv
// Mystery2 descrambler: follows the scrambler's 4-phase word schedule, recovers each
// alpha/beta byte pair and flags words that break the expected transform.
// Optional saturating mismatch counter: define MYSTERY2_DESCRAMBLER_ERRCNT_EN.
// Without it err_count is tied to zero; the err pulse is identical in both builds.
module mystery2_descrambler #(
    parameter int unsigned ERRCNT_W = 8
) (
    input logic                   clk,
    input logic                   reset,
    mystery2_descrambler_if.slave bus
);

    // Phase of the scrambler that produces the next word.
    typedef enum logic [1:0] {
        PhSwap   = 2'd0,  // byte swap of previous word
        PhHigh   = 2'd1,  // high byte repeats previous low byte, low byte is alpha
        PhLow    = 2'd2,  // low byte repeats previous high byte, high byte is beta
        PhNibble = 2'd3   // nibble order of previous word reversed
    } ph_e;

    ph_e         ph_q, ph_d;
    logic [15:0] prev_q, prev_d;
    logic [7:0]  a_cap_q, a_cap_d;
    logic        locked_q, locked_d;
    logic [7:0]  a_out_q, a_out_d;
    logic [7:0]  b_out_q, b_out_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q;
    logic        mismatch;

    logic [15:0] word;
    assign word = bus.in_word;

    // Register all tracking state and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q        <= PhSwap;
            prev_q      <= 16'h0000;
            a_cap_q     <= 8'h00;
            locked_q    <= 1'b0;
            a_out_q     <= 8'h00;
            b_out_q     <= 8'h00;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            prev_q      <= prev_d;
            a_cap_q     <= a_cap_d;
            locked_q    <= locked_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            out_valid_q <= out_valid_d;
            err_q       <= mismatch;
        end
    end

    // Next state: sync always wins; locked words are checked against the phase transform.
    always_comb begin
        ph_d        = ph_q;
        prev_d      = prev_q;
        a_cap_d     = a_cap_q;
        locked_d    = locked_q;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        out_valid_d = 1'b0;
        mismatch    = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_sync) begin
                // The reset-loaded word carries the pair directly and is never checked.
                locked_d    = 1'b1;
                prev_d      = word;
                ph_d        = PhSwap;
                a_out_d     = word[15:8];
                b_out_d     = word[7:0];
                out_valid_d = 1'b1;
            end else if (locked_q) begin
                // A bad word still becomes the reference for the next check.
                prev_d = word;
                unique case (ph_q)
                    PhSwap: begin
                        mismatch = (word != {prev_q[7:0], prev_q[15:8]});
                        ph_d     = PhHigh;
                    end
                    PhHigh: begin
                        mismatch = (word[15:8] != prev_q[7:0]);
                        a_cap_d  = word[7:0];
                        ph_d     = PhLow;
                    end
                    PhLow: begin
                        mismatch    = (word[7:0] != prev_q[15:8]);
                        a_out_d     = a_cap_q;
                        b_out_d     = word[15:8];
                        out_valid_d = 1'b1;
                        ph_d        = PhNibble;
                    end
                    PhNibble: begin
                        mismatch = (word != {prev_q[3:0], prev_q[7:4],
                                             prev_q[11:8], prev_q[15:12]});
                        ph_d     = PhSwap;
                    end
                    default: begin
                        ph_d = PhSwap;
                    end
                endcase
            end
        end
    end

    assign bus.a_out     = a_out_q;
    assign bus.b_out     = b_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.locked    = locked_q;

`ifdef MYSTERY2_DESCRAMBLER_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_q;

    // Saturating mismatch count; a sync word does not clear it, only reset does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (mismatch && (err_count_q != {ERRCNT_W{1'b1}})) begin
            err_count_q <= err_count_q + ERRCNT_W'(1);
        end
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_mystery2_descrambler.sv
// Scoreboard bench for mystery2_descrambler: the driver pushes hand-computed expected
// output events, the monitor pops and compares whenever out_valid or err is seen.
module tb_mystery2_descrambler;

    localparam int unsigned ERRCNT_W = 8;
`ifdef MYSTERY2_DESCRAMBLER_ERRCNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       ov;
        logic       er;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];

    mystery2_descrambler_if #(.ERRCNT_W(ERRCNT_W)) bus ();

    mystery2_descrambler #(.ERRCNT_W(ERRCNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: every output event must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (bus.out_valid || bus.err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got ov=%0b err=%0b a=%h b=%h, none expected",
                         bus.out_valid, bus.err, bus.a_out, bus.b_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_valid !== e.ov || bus.err !== e.er ||
                    bus.a_out !== e.a || bus.b_out !== e.b) begin
                    bad++;
                    $display("FAIL event: got ov=%0b err=%0b a=%h b=%h, want ov=%0b err=%0b a=%h b=%h",
                             bus.out_valid, bus.err, bus.a_out, bus.b_out,
                             e.ov, e.er, e.a, e.b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_a"}, 16'(bus.a_out), 16'h0);
        chk({name, "_b"}, 16'(bus.b_out), 16'h0);
        chk({name, "_ov"}, 16'(bus.out_valid), 16'h0);
        chk({name, "_err"}, 16'(bus.err), 16'h0);
        chk({name, "_locked"}, 16'(bus.locked), 16'h0);
        chk({name, "_cnt"}, 16'(bus.err_count), 16'h0);
    endtask

    task automatic expect_ev(input logic [7:0] a, input logic [7:0] b,
                             input logic ov, input logic er);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.ov = ov;
        e.er = er;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] w, input logic s);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        bus.in_sync  = s;
    endtask

    // Idle cycles also drive in_sync=1 with in_valid=0, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_sync  = (i == 0);
            bus.in_word  = 16'hFFFF;
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_word  = 16'h0000;
        bus.in_sync  = 1'b0;

        @(negedge clk);
        check_idle("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lock, then reset mid-stream.
        expect_ev(8'hA5, 8'hC3, 1'b1, 1'b0);
        send(16'hA5C3, 1'b1);
        send(16'hC3A5, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Unlocked words are ignored.
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        idle(2);
        @(negedge clk);
        check_idle("unlocked");

        // Clean sequence: sync pair then (11,22) after 0x22A5.
        expect_ev(8'hA5, 8'hC3, 1'b1, 1'b0);
        send(16'hA5C3, 1'b1);
        idle(1);
        @(negedge clk);
        chk("locked_after_sync", 16'(bus.locked), 16'h1);
        expect_ev(8'h11, 8'h22, 1'b1, 1'b0);
        send(16'hC3A5, 1'b0);
        send(16'hA511, 1'b0);
        send(16'h22A5, 1'b0);
        send(16'h5A22, 1'b0);
        send(16'h225A, 1'b0);
        idle(2);

        // Corrupted ph3 word; next ph0 reference is the corrupted word.
        expect_ev(8'hA5, 8'hC3, 1'b1, 1'b0);
        expect_ev(8'h11, 8'h22, 1'b1, 1'b0);
        expect_ev(8'h11, 8'h22, 1'b0, 1'b1);
        send(16'hA5C3, 1'b1);
        send(16'hC3A5, 1'b0);
        send(16'hA511, 1'b0);
        send(16'h22A5, 1'b0);
        send(16'h5A23, 1'b0);
        send(16'h235A, 1'b0);
        idle(2);
        @(negedge clk);
        chk("cnt_after_corrupt", 16'(bus.err_count), CntEn ? 16'd1 : 16'd0);

        // Clean sequence with gaps of 1-3 idle cycles.
        expect_ev(8'hA5, 8'hC3, 1'b1, 1'b0);
        expect_ev(8'h11, 8'h22, 1'b1, 1'b0);
        send(16'hA5C3, 1'b1);
        idle(1);
        send(16'hC3A5, 1'b0);
        idle(3);
        send(16'hA511, 1'b0);
        idle(2);
        send(16'h22A5, 1'b0);
        idle(1);
        send(16'h5A22, 1'b0);
        idle(3);
        send(16'h225A, 1'b0);
        idle(2);
        @(negedge clk);
        chk("hold_a", 16'(bus.a_out), 16'h11);
        chk("hold_b", 16'(bus.b_out), 16'h22);

        // Resync at ph2, phase restarts at 0; then a ph2 mismatch emits pair with err.
        expect_ev(8'hA5, 8'hC3, 1'b1, 1'b0);
        expect_ev(8'h0F, 8'h0F, 1'b1, 1'b0);
        expect_ev(8'h33, 8'h44, 1'b1, 1'b0);
        expect_ev(8'h55, 8'h66, 1'b1, 1'b1);
        send(16'hA5C3, 1'b1);
        send(16'hC3A5, 1'b0);
        send(16'hA511, 1'b0);
        send(16'h0F0F, 1'b1);
        send(16'h0F0F, 1'b0);
        send(16'h0F33, 1'b0);
        send(16'h440F, 1'b0);
        send(16'hF044, 1'b0);
        send(16'h44F0, 1'b0);
        send(16'hF055, 1'b0);
        send(16'h6612, 1'b0);
        idle(2);
        @(negedge clk);
        chk("cnt_after_ph2_err", 16'(bus.err_count), CntEn ? 16'd2 : 16'd0);

        // 300 mismatches: every phase fails for a constant 0x1234 stream.
        expect_ev(8'h12, 8'h34, 1'b1, 1'b0);
        send(16'h1234, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (i < 2) expect_ev(8'h12, 8'h34, 1'b0, 1'b1);
            else if ((i % 4) == 2) expect_ev(8'h34, 8'h12, 1'b1, 1'b1);
            else expect_ev(8'h34, 8'h12, 1'b0, 1'b1);
            send(16'h1234, 1'b0);
        end
        idle(3);
        @(negedge clk);
        chk("cnt_saturated", 16'(bus.err_count), CntEn ? 16'd255 : 16'd0);
        chk("locked_end", 16'(bus.locked), 16'h1);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
